f_fetch_queue: RTL and testbench



---
 rtl/mips_defs.sv | 23 ++
 rtl/f_fetch_queue.sv | 69 ++++++
 tb/tb_f_fetch_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS front-end definitions: instruction-memory window, exception codes,
// the fetch-queue entry layout and the word-address legality check.
package mips_defs;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  // Word access is illegal when misaligned or outside [lo, hi] (unsigned, inclusive).
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/f_fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr, AdEL} between fetch and decode.
// in_ready depends only on the registered occupancy so it can drive the PC enable.
module f_fetch_queue #(
  parameter int unsigned  DEPTH   = 4,
  parameter logic [31:0]  IM_BASE = mips_defs::IM_BASE,
  parameter logic [31:0]  IM_LAST = mips_defs::IM_LAST,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          out_exc,
  input  logic          out_ready,
  output logic [CW-1:0] count
);
  import mips_defs::*;

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Show-ahead head, zeroed while empty so stale storage never leaks out.
  assign head      = mem[rptr];
  assign out_pc    = out_valid ? head.pc    : 32'h0;
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_exc   = out_valid ? head.exc   : 1'b0;

  // Storage needs no reset: contents are only observable while counted.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      mem[wptr] <= '{pc: in_pc, instr: in_instr, exc: addr_err(in_pc, IM_BASE, IM_LAST)};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_queue.sv
// Bench for f_fetch_queue: directed vector table, flush/reset sequences and a
// randomized run against a queue-based reference model.
module tb_f_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = 32'h0;
  logic [31:0]   in_instr = 32'h0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_exc;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  f_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] pc, instr;
    logic        ordy;
    int          cnt;
    logic        ir, ov;
    logic [31:0] epc, einstr;
    logic        eexc;
  } vec_t;

  ent_t mq[$];
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic ref_exc(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model across the edge, sample at edge+1.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] instr, input logic ordy);
    bit can_push, do_pop;
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy;
    can_push = (mq.size() < DEPTH);
    do_pop   = (mq.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (iv && can_push) mq.push_back('{pc: pc, instr: instr, exc: ref_exc(pc)});
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] epc, ein;
    logic        eexc;
    epc = 32'h0; ein = 32'h0; eexc = 1'b0;
    if (mq.size() != 0) begin
      epc = mq[0].pc; ein = mq[0].instr; eexc = mq[0].exc;
    end
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".out_pc"},    out_pc,         epc);
    chk({tag, ".out_instr"}, out_instr,      ein);
    chk({tag, ".out_exc"},   32'(out_exc),   32'(eexc));
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                     input logic [31:0] instr, input logic ordy, input int cnt, input logic ir,
                     input logic ov, input logic [31:0] epc, input logic [31:0] einstr,
                     input logic eexc);
    vt.push_back('{rst, fl, iv, pc, instr, ordy, cnt, ir, ov, epc, einstr, eexc});
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'h3C01_0001 + ((pc - 32'h3000) >> 2);
  endfunction

  initial begin
    logic [31:0] p;
    // ---- vector table: fill, full stall, pop-only, streaming with wrap, drain, AdEL ----
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 0);           // pop while empty
    for (int i = 0; i < 4; i++) begin
      p = 32'h3000 + 32'(i * 4);
      add(0, 0, 1, p, ins_of(p), 0, i + 1, (i < 3), 1, 32'h3000, 32'h3C01_0001, 0);
    end
    add(0, 0, 1, 32'h3010, ins_of(32'h3010), 0, 4, 0, 1, 32'h3000, 32'h3C01_0001, 0);
    add(0, 0, 1, 32'h3010, ins_of(32'h3010), 1, 3, 1, 1, 32'h3004, 32'h3C01_0002, 0);
    add(0, 0, 0, 0, 0, 1, 2, 1, 1, 32'h3008, 32'h3C01_0003, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h300C, 32'h3C01_0004, 0);
    for (int i = 0; i < 6; i++) begin
      p = 32'h3010 + 32'(i * 4);
      add(0, 0, 1, p, ins_of(p), 1, 1, 1, 1, p, ins_of(p), 0);
    end
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 1, 32'h3002, 32'hDEAD_0001, 0, 1, 1, 1, 32'h3002, 32'hDEAD_0001, 1);
    add(0, 0, 1, 32'h2FFC, 32'hDEAD_0002, 1, 1, 1, 1, 32'h2FFC, 32'hDEAD_0002, 1);
    add(0, 0, 1, 32'h7000, 32'hDEAD_0003, 1, 1, 1, 1, 32'h7000, 32'hDEAD_0003, 1);
    add(0, 0, 1, 32'h6FFC, 32'hDEAD_0004, 1, 1, 1, 1, 32'h6FFC, 32'hDEAD_0004, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 0);

    foreach (vt[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].pc, vt[i].instr, vt[i].ordy);
      chk({t, ".count"},     32'(count),     32'(vt[i].cnt));
      chk({t, ".in_ready"},  32'(in_ready),  32'(vt[i].ir));
      chk({t, ".out_valid"}, 32'(out_valid), 32'(vt[i].ov));
      chk({t, ".out_pc"},    out_pc,         vt[i].epc);
      chk({t, ".out_instr"}, out_instr,      vt[i].einstr);
      chk({t, ".out_exc"},   32'(out_exc),   32'(vt[i].eexc));
    end

    // ---- flush with simultaneous push and pop at count=3 ----
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h3100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 0);
    chk("flush.pre_count", 32'(count), 32'd3);
    step(0, 1, 1, 32'h5000, 32'h2222_0000, 1);
    chk("flush.count",     32'(count),     32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.out_pc",    out_pc,         32'h0);
    chk("flush.in_ready",  32'(in_ready),  32'd1);
    step(0, 0, 1, 32'h4000, 32'h3333_0000, 0);
    chk("flush.next_pc",    out_pc,      32'h4000);
    chk("flush.next_instr", out_instr,   32'h3333_0000);
    chk("flush.next_count", 32'(count),  32'd1);

    // ---- reset mid-operation at count=2 with a push pending ----
    step(0, 0, 1, 32'h4004, 32'h3333_0001, 0);
    chk("rst.pre_count", 32'(count), 32'd2);
    step(1, 0, 1, 32'h4008, 32'h3333_0002, 0);
    chk("rst.count",     32'(count),     32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_pc",    out_pc,         32'h0);

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < 600; c++) begin
      logic [31:0] rpc;
      case ($urandom_range(0, 7))
        0:       rpc = $urandom;
        1:       rpc = 32'h2FFC;
        2:       rpc = 32'h6FFC;
        3:       rpc = 32'h7000;
        default: rpc = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      endcase
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0), rpc, $urandom, ($urandom_range(0, 2) != 0));
      chk_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
